hex_to_seg: RTL and testbench
=============================

Name: hex_to_seg

Overview:
- Registered hexadecimal-to-seven-segment decoder.
- Converts one 4-bit nibble into the segment pattern for one board digit.
- The six-digit display in lights uses one instance per digit: hex0..hex5, each fed from one nibble of the shifted scan-code history.
- Output is registered on clk with one cycle of latency; a blank input forces the digit dark.

Parameters:
- ACTIVE_LOW, 1, 1 means a lit segment drives 0 (board HEX displays); 0 means a lit segment drives 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- hex  output  7  segment drive; bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g; registered.
- nibble  input  4  hex value to display, 0x0..0xF.
- blank  input  1  1 turns all segments off on the next edge.
- lamp_test  input  1  present only with HEX_TO_SEG_LAMP_TEST_EN; 1 turns all segments on.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). Polarity and synchronicity are fixed.
- Reset: on a rising clk edge with rst=1, hex takes the "all off" value: 7'h7F when ACTIVE_LOW=1, 7'h00 when ACTIVE_LOW=0. rst overrides every other input.
- Latency: hex reflects the nibble and blank values sampled at the previous rising edge. Exactly one cycle, no handshake, a new value is accepted every cycle.
- Priority per edge, highest first: rst, then lamp_test (if compiled in), then blank, then decode.
- Decode table, active-high pattern in gfedcba order:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Letters: A, C, E, F are upper case; b, d are lower case.
- ACTIVE_LOW=1 drives the bitwise inverse of the table, e.g. 0 -> 7'h40, 8 -> 7'h00, F -> 7'h0E.
- All 16 codes are defined; no X or don't-care outputs.
- Any X on nibble outside reset must not propagate silently. Bench assertions flag it; RTL maps it to the default "all off" pattern.
- Reset asserted mid-stream: the next edge gives "all off", and decoding resumes on the first edge after rst falls.
- Blank released: the edge after blank falls shows the nibble sampled at that edge.

Optional Feature:
- Macro HEX_TO_SEG_LAMP_TEST_EN.
- When defined:
  - The lamp_test port exists.
  - lamp_test=1 (and rst=0) drives every segment lit on the next edge: 7'h00 when ACTIVE_LOW=1, 7'h7F when ACTIVE_LOW=0.
  - lamp_test overrides blank and nibble.
- When undefined:
  - The port is absent.
  - Behaviour is identical to lamp_test tied to 0.

Decomposition:
- Shared package hex_to_seg_pkg holds:
  - the segment bit-index constants SEG_A..SEG_G;
  - the 16-entry active-high pattern constant array;
  - the SEG_ALL_OFF and SEG_ALL_ON constants, expressed active-high.
- Polarity is applied in one place at the output register.
- One combinational sub-module, hex_to_seg_lut (nibble in, active-high pattern out), is natural. The top holds the priority mux, the polarity inversion and the register.

Test Plan:
- Reset: rst=1 for two edges with nibble=4'h5 -> hex=7'h7F after the first edge. Release rst -> one edge later hex=7'h12.
- Full sweep: nibble 0..F, one per cycle, blank=0 -> hex follows the active-low table one cycle later: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E.
- Blank: nibble=4'h8 with blank=1 -> hex=7'h7F. Drop blank -> next edge hex=7'h00.
- Polarity: instance with ACTIVE_LOW=0, nibble=4'hA -> hex=7'h77; blank=1 -> 7'h00.
- Reset priority: rst=1 together with blank=0 and nibble=4'h3 -> hex=7'h7F. With the macro defined, lamp_test=1 together with rst=1 also gives 7'h7F.
- Lamp test (macro defined): lamp_test=1, blank=1, nibble=4'h1 -> hex=7'h00. Release lamp_test -> next edge hex=7'h7F, since blank is still set.

Source files
------------

// File: rtl/hex_to_seg_pkg.sv
// hex_to_seg_pkg
//   Shared constants for the hexadecimal seven-segment decoder.
//   All patterns here are active-high (1 = segment lit). The top applies
//   the board polarity once, at its output register.
//   Contents:
//     SEG_A..SEG_G    bit index of each segment inside a 7-bit pattern
//     SEG_TABLE       16-entry active-high glyph table, index = nibble
//     SEG_ALL_OFF     every segment dark
//     SEG_ALL_ON      every segment lit
//     seg_drive()     converts an active-high pattern to the pin level
package hex_to_seg_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] SEG_ALL_OFF = 7'h00;
  localparam logic [6:0] SEG_ALL_ON  = 7'((1 << SEG_A) | (1 << SEG_B) | (1 << SEG_C) |
                                         (1 << SEG_D) | (1 << SEG_E) | (1 << SEG_F) |
                                         (1 << SEG_G));

  // Glyphs in gfedcba order: 0-9, A, b, C, d, E, F.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] seg_drive(input logic [6:0] pattern, input bit active_low);
    return active_low ? ~pattern : pattern;
  endfunction

endpackage

// File: rtl/hex_to_seg_lut.sv
// hex_to_seg_lut
//   Combinational nibble-to-glyph lookup, active-high output.
//   Ports:
//     nibble   in   4  hex value 0x0..0xF
//     pattern  out  7  active-high segment pattern, bit0=a .. bit6=g
//   A nibble that matches no code (X/Z bits in simulation) yields the
//   all-off pattern instead of propagating unknowns to the display.
module hex_to_seg_lut
  import hex_to_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = SEG_ALL_OFF;
    for (int i = 0; i < 16; i++) begin
      if (nibble == 4'(i)) pattern = SEG_TABLE[i];
    end
  end

endmodule

// File: rtl/hex_to_seg.sv
// hex_to_seg
//   Registered hexadecimal-to-seven-segment decoder for one display digit.
//   One cycle of latency from nibble/blank to hex; a new value every cycle.
//   Parameters:
//     ACTIVE_LOW  1: lit segment drives 0 (board HEX digits); 0: lit drives 1
//   Ports:
//     clk        in   1  system clock, rising edge
//     rst        in   1  synchronous active-high reset, forces all segments off
//     nibble     in   4  hex value to display
//     blank      in   1  turns all segments off on the next edge
//     lamp_test  in   1  only with HEX_TO_SEG_LAMP_TEST_EN; lights every segment
//     hex        out  7  registered segment drive, bit0=a .. bit6=g
//   Priority per edge: rst, lamp_test, blank, decode.
//   Build option: define HEX_TO_SEG_LAMP_TEST_EN to add the lamp_test port.
module hex_to_seg
  import hex_to_seg_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] nibble,
  input  logic       blank,
`ifdef HEX_TO_SEG_LAMP_TEST_EN
  input  logic       lamp_test,
`endif
  output logic [6:0] hex
);

  logic [6:0] glyph;
  logic [6:0] next_pattern;

  hex_to_seg_lut u_lut (
    .nibble  (nibble),
    .pattern (glyph)
  );

  // Everything up to the register stays active-high.
  always_comb begin
    next_pattern = glyph;
`ifdef HEX_TO_SEG_LAMP_TEST_EN
    if (lamp_test)  next_pattern = SEG_ALL_ON;
    else if (blank) next_pattern = SEG_ALL_OFF;
`else
    if (blank)      next_pattern = SEG_ALL_OFF;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) hex <= seg_drive(SEG_ALL_OFF, ACTIVE_LOW);
    else     hex <= seg_drive(next_pattern, ACTIVE_LOW);
  end

endmodule

// File: tb/tb_hex_to_seg.sv
module tb_hex_to_seg;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] nibble;
  logic       blank;
  logic       lamp_test;
  logic [6:0] hex_lo;
  logic [6:0] hex_hi;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hex_to_seg #(.ACTIVE_LOW(1'b1)) dut_lo (
    .clk       (clk),
    .rst       (rst),
    .nibble    (nibble),
    .blank     (blank),
`ifdef HEX_TO_SEG_LAMP_TEST_EN
    .lamp_test (lamp_test),
`endif
    .hex       (hex_lo)
  );

  hex_to_seg #(.ACTIVE_LOW(1'b0)) dut_hi (
    .clk       (clk),
    .rst       (rst),
    .nibble    (nibble),
    .blank     (blank),
`ifdef HEX_TO_SEG_LAMP_TEST_EN
    .lamp_test (lamp_test),
`endif
    .hex       (hex_hi)
  );

  // Seven-segment font written out as lit-segment sets (gfedcba).
  localparam logic [6:0] FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Board (active-low) levels for the sweep, taken directly from the digit sheet.
  localparam logic [6:0] SWEEP_LO [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Reference model: which segments should be lit after each edge.
  logic [6:0] lit_model;
  logic       model_valid = 1'b0;

  always @(posedge clk) begin
    logic [6:0] lit;
    logic       lt;
    lt = 1'b0;
`ifdef HEX_TO_SEG_LAMP_TEST_EN
    lt = lamp_test;
`endif
    if (!rst) assert (!$isunknown(nibble)) else $error("X on nibble outside reset");
    if (rst)        lit = 7'h00;
    else if (lt)    lit = 7'h7F;
    else if (blank) lit = 7'h00;
    else            lit = FONT[nibble];
    lit_model   <= lit;
    model_valid <= 1'b1;
  end

  always @(negedge clk) begin
    if (model_valid) begin
      n_tests++;
      if (hex_lo !== ~lit_model) begin
        n_fail++;
        $display("FAIL model_lo: got %h expected %h", hex_lo, ~lit_model);
      end
      n_tests++;
      if (hex_hi !== lit_model) begin
        n_fail++;
        $display("FAIL model_hi: got %h expected %h", hex_hi, lit_model);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [6:0] got, input logic [6:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  initial begin
    rst = 1'b1; nibble = 4'h5; blank = 1'b0; lamp_test = 1'b0;

    // reset held two edges, then release
    tick(); check("reset_edge1", hex_lo, 7'h7F);
    check("reset_hi", hex_hi, 7'h00);
    tick(); check("reset_edge2", hex_lo, 7'h7F);
    rst = 1'b0;
    tick(); check("reset_release", hex_lo, 7'h12);

    // full sweep
    for (int i = 0; i < 16; i++) begin
      nibble = 4'(i);
      tick();
      check($sformatf("sweep_lo_%0h", i), hex_lo, SWEEP_LO[i]);
      check($sformatf("sweep_hi_%0h", i), hex_hi, ~SWEEP_LO[i]);
    end

    // blank and its release
    nibble = 4'h8; blank = 1'b1;
    tick(); check("blank_on", hex_lo, 7'h7F);
    blank = 1'b0;
    tick(); check("blank_off", hex_lo, 7'h00);

    // active-high instance
    nibble = 4'hA;
    tick(); check("pol_hi_A", hex_hi, 7'h77);
    blank = 1'b1;
    tick(); check("pol_hi_blank", hex_hi, 7'h00);
    blank = 1'b0;

    // reset priority and mid-stream reset
    nibble = 4'h2;
    tick(); check("pre_reset", hex_lo, 7'h24);
    rst = 1'b1; nibble = 4'h3;
    tick(); check("reset_prio", hex_lo, 7'h7F);
    rst = 1'b0;
    tick(); check("reset_resume", hex_lo, 7'h30);

`ifdef HEX_TO_SEG_LAMP_TEST_EN
    rst = 1'b1; lamp_test = 1'b1;
    tick(); check("reset_over_lamp", hex_lo, 7'h7F);
    rst = 1'b0; blank = 1'b1; nibble = 4'h1;
    tick(); check("lamp_lo", hex_lo, 7'h00);
    check("lamp_hi", hex_hi, 7'h7F);
    lamp_test = 1'b0;
    tick(); check("lamp_release", hex_lo, 7'h7F);
    blank = 1'b0;
`endif

    // a short mixed stream checked by the model
    for (int i = 0; i < 20; i++) begin
      nibble = 4'($urandom_range(0, 15));
      blank  = ($urandom_range(0, 3) == 0);
      rst    = ($urandom_range(0, 9) == 0);
      tick();
    end
    rst = 1'b0; blank = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
